// File: rtl/result_tx_if.sv
// Result byte stream from the coprocessor plus the nibble/tag handshake toward the MCU.
interface result_tx_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic [3:0] port_d;
  logic       tx_tag;
  logic       ack_tag;

  modport master (
    output in_valid,
    output in_data,
    output ack_tag,
    input  in_ready,
    input  port_d,
    input  tx_tag
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  ack_tag,
    output in_ready,
    output port_d,
    output tx_tag
  );
endinterface

// File: rtl/result_tx.sv
// Queues coprocessor result bytes and presents each one to the MCU as two nibbles under a toggle/ack tag.
// Define RESULT_TX_TIMEOUT_EN to add the per-nibble acknowledge timeout and the absorbing ERROR state.
module result_tx #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1023
) (
  input  logic                   clock,
  input  logic                   reset,
  result_tx_if.slave             bus,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] level,
  output logic                   timeout_err
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  typedef enum logic [2:0] {IDLE, HI_SETUP, HI_WAIT, LO_SETUP, LO_WAIT, ERROR} state_t;

  state_t        state, state_nxt;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          q_avail, full, push, pop, start_ok;
  logic          ack_p0, ack_s, acked;
  logic [3:0]    lo_nib, port_d_q;
  logic          tx_tag_q;
  logic          ld_hi, ld_lo, toggle, timeout_hit;

  assign full         = (count == FULL_LVL);
  assign bus.in_ready = !full && !reset;
  assign push         = bus.in_valid && bus.in_ready;
  assign acked        = (ack_s == tx_tag_q);
  // IDLE acts on occupancy registered once more, fixing the push-to-port_d latency at two edges.
  assign start_ok     = q_avail && (count != '0);
  assign level        = count;
  assign busy         = (state != IDLE) || (count != '0);
  assign bus.port_d   = port_d_q;
  assign bus.tx_tag   = tx_tag_q;

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= bus.in_data;
  end

  always_ff @(posedge clock) begin
    if (ld_hi) lo_nib <= mem[rd_ptr][3:0];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      q_avail <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      q_avail <= (count != '0);
    end
  end

  // ack_tag is asynchronous: two flops before anything looks at it
  always_ff @(posedge clock) begin
    if (reset) begin
      ack_p0 <= 1'b0;
      ack_s  <= 1'b0;
    end else begin
      ack_p0 <= bus.ack_tag;
      ack_s  <= ack_p0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      port_d_q <= '0;
      tx_tag_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (ld_hi)      port_d_q <= mem[rd_ptr][7:4];
      else if (ld_lo) port_d_q <= lo_nib;
      if (toggle) tx_tag_q <= ~tx_tag_q;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (start_ok) state_nxt = HI_SETUP;
      HI_SETUP: state_nxt = HI_WAIT;
      HI_WAIT:  if (acked) state_nxt = LO_SETUP;
                else if (timeout_hit) state_nxt = ERROR;
      LO_SETUP: state_nxt = LO_WAIT;
      LO_WAIT:  if (acked) state_nxt = IDLE;
                else if (timeout_hit) state_nxt = ERROR;
      default:  state_nxt = ERROR;
    endcase
  end

  // port_d is loaded in IDLE/HI_WAIT, so it is already stable when SETUP flips the tag
  always_comb begin
    pop    = 1'b0;
    ld_hi  = 1'b0;
    ld_lo  = 1'b0;
    toggle = 1'b0;
    case (state)
      IDLE: begin
        pop   = start_ok;
        ld_hi = start_ok;
      end
      HI_SETUP, LO_SETUP: toggle = 1'b1;
      HI_WAIT:            ld_lo  = acked;
      default: ;
    endcase
  end

`ifdef RESULT_TX_TIMEOUT_EN
  logic [15:0] wait_cnt;
  logic        in_wait, wait_clr, wait_inc, err_q;

  assign in_wait     = (state == HI_WAIT) || (state == LO_WAIT);
  assign wait_clr    = (state == HI_SETUP) || (state == LO_SETUP);
  assign wait_inc    = in_wait && !acked;
  assign timeout_hit = (wait_cnt == 16'(TIMEOUT - 1));
  assign timeout_err = err_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      if (wait_clr)      wait_cnt <= '0;
      else if (wait_inc) wait_cnt <= wait_cnt + 1'b1;
      if (wait_inc && timeout_hit) err_q <= 1'b1;
    end
  end
`else
  // Without the timeout the wait is unbounded; TIMEOUT is never 0, so this stays low.
  assign timeout_hit = (TIMEOUT == 0);
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_result_tx.sv
// Bench for result_tx: randomized byte traffic and an MCU tag/ack model checked against a nibble queue.
module tb_result_tx;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 16;

  logic                   clock = 1'b0;
  logic                   reset = 1'b1;
  logic                   busy;
  logic                   timeout_err;
  logic [$clog2(DEPTH):0] level;

  result_tx_if bus();

  result_tx #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clock       (clock),
    .reset       (reset),
    .bus         (bus),
    .busy        (busy),
    .level       (level),
    .timeout_err (timeout_err)
  );

  always #5 clock = ~clock;

  int         n_cmp = 0;
  int         n_bad = 0;
  bit         mcu_en = 1'b0;
  int         mcu_delay = 0;
  logic [3:0] got_nib[$];
  logic       got_tag[$];
  logic       last_tag = 1'b0;
  bit         pending = 1'b0;
  int         ack_cnt = 0;

  // MCU model: records every presented nibble on a tag change, answers after mcu_delay cycles
  always begin
    @(negedge clock);
    #1;
    if (reset) begin
      last_tag    = 1'b0;
      pending     = 1'b0;
      bus.ack_tag = 1'b0;
    end else begin
      if (bus.tx_tag !== last_tag) begin
        last_tag = bus.tx_tag;
        got_nib.push_back(bus.port_d);
        got_tag.push_back(bus.tx_tag);
        pending = 1'b1;
        ack_cnt = mcu_delay;
      end
      if (mcu_en && pending) begin
        if (ack_cnt <= 0) begin
          bus.ack_tag = last_tag;
          pending     = 1'b0;
        end else begin
          ack_cnt--;
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clock);
    reset  = 1'b1;
    mcu_en = 1'b0;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic push_byte(input logic [7:0] b, output bit acc);
    @(negedge clock);
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    #1;
    acc = bus.in_ready;
    @(posedge clock);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_done(input int expect_n, input int limit);
    for (int i = 0; i < limit; i++) begin
      @(posedge clock);
      #1;
      if (got_nib.size() >= expect_n && busy === 1'b0) break;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL rst_in_ready_during: got %b want 0", bus.in_ready); end
    n_cmp++; if (level !== 3'd0) begin n_bad++; $display("FAIL rst_level: got %0d want 0", level); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_cmp++; if (bus.port_d !== 4'h0) begin n_bad++; $display("FAIL rst_port_d: got %h want 0", bus.port_d); end
    n_cmp++; if (bus.tx_tag !== 1'b0) begin n_bad++; $display("FAIL rst_tx_tag: got %b want 0", bus.tx_tag); end
    n_cmp++; if (timeout_err !== 1'b0) begin n_bad++; $display("FAIL rst_timeout_err: got %b want 0", timeout_err); end
    reset = 1'b0;
    #1;
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_in_ready_after: got %b want 1", bus.in_ready); end
  endtask

  task automatic test_latency();
    int base;
    do_reset();
    base = got_nib.size();
    mcu_delay = 1;
    @(negedge clock);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hC3;
    @(posedge clock);
    #1;
    bus.in_valid = 1'b0;
    @(negedge clock);
    n_cmp++; if (bus.port_d !== 4'h0) begin n_bad++; $display("FAIL lat_port_d_N: got %h want 0", bus.port_d); end
    n_cmp++; if (level !== 3'd1) begin n_bad++; $display("FAIL lat_level_N: got %0d want 1", level); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL lat_busy_N: got %b want 1", busy); end
    @(posedge clock); #1;
    n_cmp++; if (bus.port_d !== 4'h0) begin n_bad++; $display("FAIL lat_port_d_N1: got %h want 0", bus.port_d); end
    @(posedge clock); #1;
    n_cmp++; if (bus.port_d !== 4'hC) begin n_bad++; $display("FAIL lat_port_d_N2: got %h want c", bus.port_d); end
    n_cmp++; if (bus.tx_tag !== 1'b0) begin n_bad++; $display("FAIL lat_tag_N2: got %b want 0", bus.tx_tag); end
    n_cmp++; if (level !== 3'd0) begin n_bad++; $display("FAIL lat_level_N2: got %0d want 0", level); end
    @(posedge clock); #1;
    n_cmp++; if (bus.tx_tag !== 1'b1) begin n_bad++; $display("FAIL lat_tag_N3: got %b want 1", bus.tx_tag); end
    mcu_en = 1'b1;
    wait_done(base + 2, 100);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL lat_done: busy got %b want 0", busy); end
    n_cmp++; if (got_nib.size() != base + 2 || got_nib[base+1] !== 4'h3) begin n_bad++; $display("FAIL lat_lo_nibble: count %0d want %0d", got_nib.size(), base + 2); end
  endtask

  task automatic test_single();
    int base;
    bit a;
    do_reset();
    base      = got_nib.size();
    mcu_delay = 5;
    mcu_en    = 1'b1;
    push_byte(8'hA5, a);
    wait_done(base + 2, 200);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL a5_busy_end: got %b want 0", busy); end
    if (got_nib.size() >= base + 2) begin
      n_cmp++; if (got_nib[base] !== 4'hA) begin n_bad++; $display("FAIL a5_hi: got %h want a", got_nib[base]); end
      n_cmp++; if (got_nib[base+1] !== 4'h5) begin n_bad++; $display("FAIL a5_lo: got %h want 5", got_nib[base+1]); end
      n_cmp++; if (got_tag[base] !== 1'b1) begin n_bad++; $display("FAIL a5_tag0: got %b want 1", got_tag[base]); end
      n_cmp++; if (got_tag[base+1] !== 1'b0) begin n_bad++; $display("FAIL a5_tag1: got %b want 0", got_tag[base+1]); end
    end else begin
      n_cmp++; n_bad++; $display("FAIL a5_nibbles: got %0d nibbles want 2", got_nib.size() - base);
    end
    n_cmp++; if (bus.port_d !== 4'h5) begin n_bad++; $display("FAIL a5_port_d_hold: got %h want 5", bus.port_d); end
  endtask

  task automatic test_back_to_back();
    int base;
    int acc_n;
    bit a;
    do_reset();
    base  = got_nib.size();
    acc_n = 0;
    for (int k = 0; k < 6; k++) begin
      push_byte(8'h11 + 8'(k), a);
      acc_n += int'(a);
    end
    @(negedge clock);
    n_cmp++; if (acc_n !== 5) begin n_bad++; $display("FAIL b2b_accepted: got %0d want 5", acc_n); end
    n_cmp++; if (level !== 3'd4) begin n_bad++; $display("FAIL b2b_level: got %0d want 4", level); end
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_in_ready: got %b want 0", bus.in_ready); end
    repeat (5) @(posedge clock);
    @(negedge clock);
    n_cmp++; if (level !== 3'd4) begin n_bad++; $display("FAIL b2b_level_hold: got %0d want 4", level); end
    mcu_delay = 2;
    mcu_en    = 1'b1;
    wait_done(base + 10, 400);
    n_cmp++; if (got_nib.size() != base + 10) begin n_bad++; $display("FAIL b2b_count: got %0d want 10", got_nib.size() - base); end
    for (int k = 0; k < 5 && got_nib.size() >= base + 10; k++) begin
      n_cmp++; if (got_nib[base+2*k] !== 4'h1) begin n_bad++; $display("FAIL b2b_hi%0d: got %h want 1", k, got_nib[base+2*k]); end
      n_cmp++; if (got_nib[base+2*k+1] !== 4'(k + 1)) begin n_bad++; $display("FAIL b2b_lo%0d: got %h want %h", k, got_nib[base+2*k+1], k + 1); end
    end
  endtask

  task automatic test_ack_latency();
    bit a;
    bit found;
    do_reset();
    mcu_delay = 0;
    mcu_en    = 1'b1;
    push_byte(8'h3C, a);
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clock); #1;
      if (bus.tx_tag === 1'b1) begin found = 1'b1; break; end
    end
    n_cmp++; if (found !== 1'b1) begin n_bad++; $display("FAIL ackl_toggle: got %b want 1", found); end
    @(posedge clock); #1;
    n_cmp++; if (bus.port_d !== 4'h3) begin n_bad++; $display("FAIL ackl_T1: got %h want 3", bus.port_d); end
    @(posedge clock); #1;
    n_cmp++; if (bus.port_d !== 4'h3) begin n_bad++; $display("FAIL ackl_T2: got %h want 3", bus.port_d); end
    @(posedge clock); #1;
    n_cmp++; if (bus.port_d !== 4'hC) begin n_bad++; $display("FAIL ackl_T3: got %h want c", bus.port_d); end
    n_cmp++; if (bus.tx_tag !== 1'b1) begin n_bad++; $display("FAIL ackl_tag_T3: got %b want 1", bus.tx_tag); end
    @(posedge clock); #1;
    n_cmp++; if (bus.tx_tag !== 1'b0) begin n_bad++; $display("FAIL ackl_tag_T4: got %b want 0", bus.tx_tag); end
    wait_done(0, 100);
  endtask

  task automatic test_random();
    int         base;
    bit         a;
    logic [7:0] b;
    logic [3:0] exp_q[$];
    do_reset();
    base   = got_nib.size();
    mcu_en = 1'b1;
    for (int n = 0; n < 40; n++) begin
      b         = 8'($urandom);
      mcu_delay = int'($urandom_range(0, 6));
      repeat ($urandom_range(0, 3)) @(posedge clock);
      a = 1'b0;
      for (int t = 0; t < 200 && !a; t++) push_byte(b, a);
      if (a) begin
        exp_q.push_back(b[7:4]);
        exp_q.push_back(b[3:0]);
      end
    end
    wait_done(base + exp_q.size(), 5000);
    n_cmp++; if (got_nib.size() != base + exp_q.size()) begin n_bad++; $display("FAIL rnd_count: got %0d want %0d", got_nib.size() - base, exp_q.size()); end
    for (int i = 0; i < exp_q.size() && base + i < got_nib.size(); i++) begin
      n_cmp++; if (got_nib[base+i] !== exp_q[i]) begin n_bad++; $display("FAIL rnd_nib%0d: got %h want %h", i, got_nib[base+i], exp_q[i]); end
      n_cmp++; if (got_tag[base+i] !== ((i % 2) == 0)) begin n_bad++; $display("FAIL rnd_tag%0d: got %b want %b", i, got_tag[base+i], (i % 2) == 0); end
    end
    n_cmp++; if (level !== 3'd0 || busy !== 1'b0) begin n_bad++; $display("FAIL rnd_idle: level %0d busy %b want 0 0", level, busy); end
  endtask

  task automatic test_reset_mid();
    bit a;
    do_reset();
    push_byte(8'h81, a);
    push_byte(8'h82, a);
    push_byte(8'h83, a);
    for (int i = 0; i < 10 && bus.tx_tag !== 1'b1; i++) begin
      @(posedge clock); #1;
    end
    n_cmp++; if (level !== 3'd2 || bus.tx_tag !== 1'b1) begin n_bad++; $display("FAIL rmid_setup: level %0d tag %b want 2 1", level, bus.tx_tag); end
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    n_cmp++; if (bus.port_d !== 4'h0) begin n_bad++; $display("FAIL rmid_port_d: got %h want 0", bus.port_d); end
    n_cmp++; if (bus.tx_tag !== 1'b0) begin n_bad++; $display("FAIL rmid_tx_tag: got %b want 0", bus.tx_tag); end
    n_cmp++; if (level !== 3'd0) begin n_bad++; $display("FAIL rmid_level: got %0d want 0", level); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rmid_busy: got %b want 0", busy); end
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL rmid_in_ready: got %b want 1", bus.in_ready); end
    repeat (5) @(posedge clock);
    #1;
    n_cmp++; if (busy !== 1'b0 || bus.tx_tag !== 1'b0) begin n_bad++; $display("FAIL rmid_quiet: busy %b tag %b want 0 0", busy, bus.tx_tag); end
  endtask

`ifdef RESULT_TX_TIMEOUT_EN
  task automatic test_timeout();
    bit a;
    int acc_n;
    do_reset();
    push_byte(8'hA7, a);
    for (int i = 0; i < 10 && bus.tx_tag !== 1'b1; i++) begin
      @(posedge clock); #1;
    end
    repeat (15) @(posedge clock);
    #1;
    n_cmp++; if (timeout_err !== 1'b0) begin n_bad++; $display("FAIL to_early: got %b want 0", timeout_err); end
    @(posedge clock); #1;
    n_cmp++; if (timeout_err !== 1'b1) begin n_bad++; $display("FAIL to_at_16: got %b want 1", timeout_err); end
    acc_n = 0;
    for (int k = 0; k < 5; k++) begin
      push_byte(8'h50 + 8'(k), a);
      acc_n += int'(a);
    end
    repeat (10) @(posedge clock);
    #1;
    n_cmp++; if (acc_n !== 4) begin n_bad++; $display("FAIL to_accepted: got %0d want 4", acc_n); end
    n_cmp++; if (level !== 3'd4) begin n_bad++; $display("FAIL to_level: got %0d want 4", level); end
    n_cmp++; if (bus.port_d !== 4'hA || bus.tx_tag !== 1'b1) begin n_bad++; $display("FAIL to_hold: port_d %h tag %b want a 1", bus.port_d, bus.tx_tag); end
    n_cmp++; if (busy !== 1'b1 || timeout_err !== 1'b1) begin n_bad++; $display("FAIL to_sticky: busy %b err %b want 1 1", busy, timeout_err); end
  endtask
`else
  task automatic test_long_wait();
    int base;
    bit a;
    do_reset();
    base = got_nib.size();
    push_byte(8'h96, a);
    repeat (2000) @(posedge clock);
    #1;
    n_cmp++; if (timeout_err !== 1'b0) begin n_bad++; $display("FAIL lw_err: got %b want 0", timeout_err); end
    n_cmp++; if (bus.port_d !== 4'h9 || bus.tx_tag !== 1'b1) begin n_bad++; $display("FAIL lw_hold: port_d %h tag %b want 9 1", bus.port_d, bus.tx_tag); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL lw_busy: got %b want 1", busy); end
    mcu_delay = 2;
    mcu_en    = 1'b1;
    wait_done(base + 2, 100);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL lw_done: busy got %b want 0", busy); end
    n_cmp++; if (got_nib.size() != base + 2 || got_nib[base] !== 4'h9 || got_nib[base+1] !== 4'h6) begin n_bad++; $display("FAIL lw_nibbles: count %0d want 2 (9,6)", got_nib.size() - base); end
  endtask
`endif

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    test_reset();
    test_latency();
    test_single();
    test_back_to_back();
    test_ack_latency();
    test_random();
    test_reset_mid();
`ifdef RESULT_TX_TIMEOUT_EN
    test_timeout();
`else
    test_long_wait();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
